// File: rtl/execute_cc.sv
// Y86-64 execute stage: ALU, condition-code register and branch/cmov condition.
// valE, cnd and instr_err are combinational; CC and the halt latch are clocked.
module execute_cc #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic [WIDTH-1:0] valE,
    output logic             cnd,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             halted,
    output logic             instr_err
);

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e state_q, state_d;
    logic   zf_q, zf_d;
    logic   sf_q, sf_d;
    logic   of_q, of_d;
    logic   cc_we;
    logic   ovf;
    logic   sxo;

    always_comb begin
        valE = '0;
        case (icode)
            I_RRMOV:          valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_OPQ: begin
                case (ifun)
                    4'd0:    valE = valB + valA;
                    4'd1:    valE = valB - valA;
                    4'd2:    valE = valB & valA;
                    4'd3:    valE = valB ^ valA;
                    default: valE = '0;
                endcase
            end
            I_CALL, I_PUSH:   valE = valB - WIDTH'(8);
            I_RET, I_POP:     valE = valB + WIDTH'(8);
            default:          valE = '0;
        endcase
    end

    // cnd always reads the pre-edge flags, never the ones being computed.
    assign sxo = sf_q ^ of_q;

    always_comb begin
        cnd = 1'b0;
        if (icode == I_RRMOV || icode == I_JXX) begin
            case (ifun)
                4'd0:    cnd = 1'b1;
                4'd1:    cnd = sxo | zf_q;
                4'd2:    cnd = sxo;
                4'd3:    cnd = zf_q;
                4'd4:    cnd = !zf_q;
                4'd5:    cnd = !sxo;
                4'd6:    cnd = !sxo && !zf_q;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign instr_err = (icode > I_POP)
                    || (icode == I_OPQ && ifun > 4'd3)
                    || ((icode == I_RRMOV || icode == I_JXX) && ifun > 4'd6);

    always_comb begin
        ovf = 1'b0;
        case (ifun)
            4'd0: ovf = (valA[WIDTH-1] == valB[WIDTH-1])
                     && (valE[WIDTH-1] != valB[WIDTH-1]);
            4'd1: ovf = (valA[WIDTH-1] != valB[WIDTH-1])
                     && (valE[WIDTH-1] != valB[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end

    assign cc_we = (icode == I_OPQ) && (ifun <= 4'd3) && (state_q == RUN);

    always_comb begin
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        state_d = state_q;
        if (cc_we) begin
            zf_d = (valE == '0);
            sf_d = valE[WIDTH-1];
            of_d = ovf;
        end
        if (state_q == RUN && icode == I_HALT) begin
            state_d = HALT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zf_q    <= 1'b1;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            state_q <= RUN;
        end else begin
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            state_q <= state_d;
        end
    end

    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;
    assign halted = (state_q == HALT);

endmodule

// File: tb/tb_execute_cc.sv
// Scoreboard bench for execute_cc: directed steps push expectations,
// a negedge monitor pops and compares every output of that cycle.
module tb_execute_cc;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic        halted;
    logic        instr_err;

    execute_cc #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .valE      (valE),
        .cnd       (cnd),
        .zf        (zf),
        .sf        (sf),
        .of        (of),
        .halted    (halted),
        .instr_err (instr_err)
    );

    typedef struct {
        int          idx;
        logic [63:0] e;
        logic        c;
        logic        z;
        logic        s;
        logic        o;
        logic        h;
        logic        er;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   nstep    = 0;

    localparam logic [63:0] M = 64'h8000_0000_0000_0000;
    localparam logic [63:0] Q = 64'h4000_0000_0000_0000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input int idx, input string nm,
                                input logic [63:0] act,
                                input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL step%0d %s: got %h expected %h",
                     idx, nm, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk(x.idx, "valE", valE, x.e);
            chk(x.idx, "cnd", 64'(cnd), 64'(x.c));
            chk(x.idx, "zf", 64'(zf), 64'(x.z));
            chk(x.idx, "sf", 64'(sf), 64'(x.s));
            chk(x.idx, "of", 64'(of), 64'(x.o));
            chk(x.idx, "halted", 64'(halted), 64'(x.h));
            chk(x.idx, "instr_err", 64'(instr_err), 64'(x.er));
        end
    end

    task automatic step(input logic r, input logic [3:0] ic,
                        input logic [3:0] f, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c,
                        input logic [63:0] e, input logic cc,
                        input logic z, input logic s, input logic o,
                        input logic h, input logic er);
        exp_t x;
        rst   = r;
        icode = ic;
        ifun  = f;
        valA  = a;
        valB  = b;
        valC  = c;
        nstep++;
        x = '{nstep, e, cc, z, s, o, h, er};
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        icode = 4'h1;
        ifun  = 4'h0;
        valA  = '0;
        valB  = '0;
        valC  = '0;
        repeat (2) @(posedge clk);
        #1;
        //    rst ic    f     valA    valB    valC   valE   c  z  s  o  h  e
        step(0, 4'h6, 4'h0, Q, Q, 0, M, 0, 1, 0, 0, 0, 0);
        step(0, 4'h7, 4'h2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 4'h7, 4'h5, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        step(0, 4'h6, 4'h1, 64'h34_2486_7AEC, 64'h34_2486_7AEC, 0,
             0, 0, 0, 1, 1, 0, 0);
        step(0, 4'h2, 4'h4, 64'h1234, 64'h99, 0, 64'h1234,
             0, 1, 0, 0, 0, 0);
        step(0, 4'h2, 4'h3, 64'h1234, 64'h99, 0, 64'h1234,
             1, 1, 0, 0, 0, 0);
        step(0, 4'h6, 4'h1, 5, 3, 0, 64'hFFFF_FFFF_FFFF_FFFE,
             0, 1, 0, 0, 0, 0);
        step(0, 4'h7, 4'h1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        // async reset: flags must clear before any clock edge
        step(1, 4'h7, 4'h3, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 4'h5, 4'h0, 0, 64'h100, 64'h28, 64'h128,
             0, 1, 0, 0, 0, 0);
        step(0, 4'hA, 4'h0, 0, 64'h100, 0, 64'hF8, 0, 1, 0, 0, 0, 0);
        step(0, 4'hB, 4'h0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h4,
             0, 1, 0, 0, 0, 0);
        step(0, 4'h3, 4'h0, 7, 9, 64'hDEAD, 64'hDEAD, 0, 1, 0, 0, 0, 0);
        step(0, 4'h4, 4'h0, 7, 64'h10, 64'h20, 64'h30, 0, 1, 0, 0, 0, 0);
        step(0, 4'h8, 4'h0, 0, 64'h10, 0, 64'h8, 0, 1, 0, 0, 0, 0);
        step(0, 4'h9, 4'h0, 0, 0, 0, 64'h8, 0, 1, 0, 0, 0, 0);
        step(0, 4'h6, 4'h1, M, 1, 0, 64'h8000_0000_0000_0001,
             0, 1, 0, 0, 0, 0);
        step(0, 4'h7, 4'h6, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        step(0, 4'h6, 4'h2, M, M, 0, M, 0, 0, 1, 1, 0, 0);
        step(0, 4'h7, 4'h2, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 4'h6, 4'h5, 1, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 4'h6, 4'h4, 1, 2, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 4'hC, 4'h0, 1, 2, 3, 0, 0, 0, 1, 0, 0, 1);
        step(0, 4'h7, 4'h7, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 4'h7, 4'h0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step(0, 4'h6, 4'h3, 5, 5, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 4'h6, 4'h0, 1, 2, 0, 64'h3, 0, 1, 0, 0, 0, 0);
        step(0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 4'h6, 4'h3, 5, 5, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 4'h7, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        step(0, 4'h7, 4'h3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 4'h1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step(0, 4'h1, 4'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0",
                     q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/execute_cc.md
# execute_cc

Execute stage of the sequential Y86-64 processor, directly downstream of the register file. It takes `valA`/`valB` read by decode plus `valC` from fetch, computes `valE` with the ALU, holds the condition-code register (ZF/SF/OF), and evaluates `cnd` for cmovXX/jXX. `valE` and `cnd` are combinational so the register file and the PC logic can consume them in the same cycle. The CC register and a halt latch are updated on the rising clock edge.

## Interface
Parameters:
- `WIDTH`, 64: datapath width. Only 64 is supported.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `icode`  in  4  instruction code from fetch.
- `ifun`  in  4  function code from fetch.
- `valA`  in  64  register-file read port A.
- `valB`  in  64  register-file read port B.
- `valC`  in  64  constant word from fetch.
- `valE`  out  64  ALU result (combinational).
- `cnd`  out  1  condition result (combinational, uses current CC).
- `zf`, `sf`, `of`  out  1 each  current CC register contents.
- `halted`  out  1  set once a halt has been clocked.
- `instr_err`  out  1  combinational: icode > 4'hB, or OPq with ifun > 3, or cmovXX/jXX with ifun > 6.

## Operation
- ALU (`valE`), by icode:
  - 2 rrmovq/cmovXX: `valA`.
  - 3 irmovq: `valC`.
  - 4 rmmovq, 5 mrmovq: `valB + valC`.
  - 6 OPq, by ifun: 0 gives `valB + valA`; 1 gives `valB - valA`; 2 gives `valB & valA`; 3 gives `valB ^ valA`; other ifun gives 0.
  - 8 call, A pushq: `valB - 8`.
  - 9 ret, B popq: `valB + 8`.
  - 0, 1, 7 and all other icodes: 0.
- Arithmetic is modulo 2^64 and carries are discarded.
- `cnd` is evaluated only for icode 2 and 7; every other icode gives `cnd = 0`. By ifun:
  - 0: 1.
  - 1 le: `(sf^of)|zf`.
  - 2 l: `sf^of`.
  - 3 e: `zf`.
  - 4 ne: `!zf`.
  - 5 ge: `!(sf^of)`.
  - 6 g: `!(sf^of) & !zf`.
  - >6: 0.
- CC update happens at the rising edge only when icode = 6, ifun ≤ 3 and `halted = 0`:
  - ZF = (`valE` == 0).
  - SF = `valE[63]`.
  - OF for add: `valA[63]==valB[63] && valE[63]!=valB[63]`.
  - OF for sub: `valA[63]!=valB[63] && valE[63]!=valB[63]`.
  - OF for and/xor: 0.
- An OPq with an invalid ifun leaves the CC unchanged.
- Halt state machine has two states, RUN and HALT:
  - RUN → HALT at the rising edge when icode = 0.
  - HALT is left only by `rst`.
  - In HALT the CC is frozen. `valE`/`cnd` stay combinational and live.

## Timing
- Reset, asynchronous: `zf=1`, `sf=0`, `of=0`, `halted=0`, state RUN. These take effect immediately on `rst` rising, independent of `clk`.
- Reset asserted mid-cycle overrides a pending CC update or halt. No edge taken while `rst=1` changes state.
- Latency of `valE` and `cnd`: zero cycles, combinational from inputs and current CC.
- Latency of the CC: new flags are visible after the edge that closes the OPq cycle. A jXX/cmovXX in the following cycle sees them.
- Same-cycle ordering: `cnd` always uses the pre-edge CC. An OPq never affects its own cycle's `cnd`, and is only ever the sole instruction in its cycle.
- Halt and OPq are mutually exclusive by icode, so no priority is needed. `instr_err` does not block halting.

## Test plan
- Reset: assert `rst` with no clock edge → `zf=1`, `sf=0`, `of=0`, `halted=0` immediately. With icode=7, ifun=3 → `cnd=1`.
- Add overflow: icode=6, ifun=0, valA=valB=64'h4000_0000_0000_0000 → `valE`=64'h8000_0000_0000_0000. After the edge: `zf=0`, `sf=1`, `of=1`. Next cycle with icode=7, ifun=2 (l) → `cnd=0`.
- Sub to zero: icode=6, ifun=1, valA=valB=64'h3424867AEC → `valE=0`. After the edge: `zf=1`, `sf=0`, `of=0`. Then cmovXX with ifun=4 → `cnd=0`, `valE`=valA.
- Address and stack: icode=5, valB=64'h100, valC=64'h28 → `valE`=64'h128. icode=A, valB=64'h100 → 64'hF8. icode=B, valB=64'hFFFF_FFFF_FFFF_FFFC → 64'h4 (wrap).
- Halt freeze: clock icode=0 → `halted=1`. Then clock icode=6, ifun=3, valA=valB=5 → `valE=0` but flags unchanged. Assert `rst` → `halted=0`.
- Errors: icode=6, ifun=5 → `valE=0`, `instr_err=1`, CC unchanged after the edge. icode=C → `instr_err=1`, `valE=0`, `cnd=0`.
